vc_packet_buffer: RTL
=====================

VC_PACKET_BUFFER -- requirements
Module: vc_packet_buffer

Interface
REQ-001 Parameter PACKET_WIDTH, default 55: flit/packet data width in bits.
REQ-002 Parameter VC_NUM, default 4: number of virtual channels (power of two, >= 2).
REQ-003 Parameter VC_DEPTH_LOG2, default 2: log2 of per-VC FIFO depth, so depth is 4.
REQ-004 Derived constants: VCW = log2(VC_NUM); CNTW = VC_DEPTH_LOG2+1.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_vc  input  VCW  target VC of write.
REQ-009 wr_data  input  PACKET_WIDTH  data to store.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_vc  input  VCW  source VC of read.
REQ-012 rd_data  output  PACKET_WIDTH  registered read data.
REQ-013 rd_valid  output  1  high exactly one cycle after an accepted read.
REQ-014 vc_full  output  VC_NUM  bit i set when VC i holds 2^VC_DEPTH_LOG2 entries.
REQ-015 vc_empty  output  VC_NUM  bit i set when VC i holds 0 entries.
REQ-016 vc_count  output  VC_NUM*CNTW  per-VC occupancy; VC i in bits [i*CNTW +: CNTW].

Function
REQ-017 Storage SHALL be one shared array of VC_NUM*2^VC_DEPTH_LOG2 words, addressed {vc, pointer}.
REQ-018 Each VC SHALL have independent VC_DEPTH_LOG2-bit write and read pointers, wrapping modulo depth.
REQ-019 Write accepted iff wr_en=1 and vc_full[wr_vc]=0 (pre-edge value); on acceptance, data stored at write pointer, pointer +1, count +1.
REQ-020 Write to a full VC SHALL be dropped: no storage, pointer or count change, even if the same VC is read that cycle.
REQ-021 Read accepted iff rd_en=1 and vc_empty[rd_vc]=0 (pre-edge value); rd_data loads the entry at read pointer, pointer +1, count -1.
REQ-022 Read of an empty VC SHALL be ignored, including when the same VC is written that cycle (no write-to-read bypass).
REQ-023 Read latency SHALL be 1 cycle: rd_valid=1 and rd_data valid in the cycle after acceptance.
REQ-024 When no read is accepted, rd_valid=0 and rd_data SHALL hold its previous value.
REQ-025 Simultaneous accepted write and read on the same VC SHALL leave its count unchanged and advance both pointers.
REQ-026 Simultaneous accepted operations on different VCs SHALL proceed independently in the same cycle.
REQ-027 vc_full, vc_empty and vc_count SHALL be registered-state-derived and reflect updates in the cycle after the edge.

Reset
REQ-028 reset=0 SHALL asynchronously clear all pointers and counts, rd_data to 0 and rd_valid to 0; vc_empty to all-ones, vc_full to all-zeros.
REQ-029 Storage array contents SHALL NOT be reset; reset mid-operation SHALL discard all buffered entries and any read in flight.

Configuration
REQ-030 Macro VC_PACKET_BUFFER_PARITY_EN: when defined, each word stores one extra even-parity bit computed on write, and output rd_par_err (1 bit) is asserted with rd_valid when the stored parity mismatches the read data; reset value 0.
REQ-031 Without VC_PACKET_BUFFER_PARITY_EN, no parity bit is stored and rd_par_err does not exist.

Structure
REQ-032 A shared package noc_buf_pkg SHALL hold the default PACKET_WIDTH, VC_NUM, VC_DEPTH_LOG2 constants and the clog2-based VCW/CNTW derivation.
REQ-033 Per-VC pointer/count logic SHALL be one sub-module vc_fifo_ctrl, instantiated VC_NUM times; the storage array stays in the top module.

Verification
REQ-034 After reset: vc_empty=4'b1111, vc_full=4'b0000, all vc_count=0, rd_valid=0, rd_data=0.
REQ-035 Write 0x11,0x22,0x33,0x44 to VC2, then 5th write 0x55 -> vc_full[2]=1, count=4, 0x55 dropped; four reads return 0x11..0x44 in order with rd_valid each following cycle.
REQ-036 Read VC1 while empty and write VC1 same cycle -> rd_valid=0 next cycle, vc_count[VC1]=1.
REQ-037 VC0 holding 2 entries, write and read VC0 same cycle for 6 cycles -> count stays 2, pointers wrap, data returned in FIFO order.
REQ-038 Write VC3 data 0xAA while reading VC0 (holding 0x5) -> rd_data=0x5, VC3 count=1, VC0 count decremented.
REQ-039 Assert reset with VC2 holding 3 entries and a read in flight -> rd_valid=0 immediately, VC2 empty; with parity macro, a forced stored-bit flip yields rd_par_err=1 with rd_valid.

Source files
------------

// File: rtl/vc_packet_buffer_pkg.sv
// Shared defaults and width helpers for the NoC virtual-channel packet buffer.
package noc_buf_pkg;

    localparam int DEF_PACKET_WIDTH  = 55;
    localparam int DEF_VC_NUM        = 4;
    localparam int DEF_VC_DEPTH_LOG2 = 2;

    // A single-VC build would give $clog2(1) = 0, so keep the select at least one bit wide.
    function automatic int calcVcw(input int vcNum);
        return (vcNum > 1) ? $clog2(vcNum) : 1;
    endfunction

    // Occupancy runs from 0 to 2^depthLog2 inclusive, so it needs one bit more than a pointer.
    function automatic int calcCntw(input int depthLog2);
        return depthLog2 + 1;
    endfunction

endpackage

// File: rtl/vc_packet_buffer_if.sv
// Write/read/status bundle of vc_packet_buffer; rd_par_err exists only with VC_PACKET_BUFFER_PARITY_EN.
interface vc_packet_buffer_if
    import noc_buf_pkg::*;
#(
    parameter int PACKET_WIDTH  = DEF_PACKET_WIDTH,
    parameter int VC_NUM        = DEF_VC_NUM,
    parameter int VC_DEPTH_LOG2 = DEF_VC_DEPTH_LOG2
);
    localparam int VCW  = calcVcw(VC_NUM);
    localparam int CNTW = calcCntw(VC_DEPTH_LOG2);

    logic                     wr_en;
    logic [VCW-1:0]           wr_vc;
    logic [PACKET_WIDTH-1:0]  wr_data;
    logic                     rd_en;
    logic [VCW-1:0]           rd_vc;
    logic [PACKET_WIDTH-1:0]  rd_data;
    logic                     rd_valid;
    logic [VC_NUM-1:0]        vc_full;
    logic [VC_NUM-1:0]        vc_empty;
    logic [VC_NUM*CNTW-1:0]   vc_count;
`ifdef VC_PACKET_BUFFER_PARITY_EN
    logic                     rd_par_err;
`endif

    modport master (
        output wr_en, wr_vc, wr_data, rd_en, rd_vc,
`ifdef VC_PACKET_BUFFER_PARITY_EN
        input  rd_par_err,
`endif
        input  rd_data, rd_valid, vc_full, vc_empty, vc_count
    );

    modport slave (
        input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
`ifdef VC_PACKET_BUFFER_PARITY_EN
        output rd_par_err,
`endif
        output rd_data, rd_valid, vc_full, vc_empty, vc_count
    );

endinterface

// File: rtl/vc_packet_buffer_fifo_ctrl.sv
// Pointer and occupancy control for one virtual channel; acceptance is decided from the current count.
module vc_fifo_ctrl
    import noc_buf_pkg::*;
#(
    parameter int VC_DEPTH_LOG2 = DEF_VC_DEPTH_LOG2,
    localparam int CNTW         = calcCntw(VC_DEPTH_LOG2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wrReq,
    input  logic                     rdReq,
    output logic                     wrAccept,
    output logic                     rdAccept,
    output logic [VC_DEPTH_LOG2-1:0] wrPtr,
    output logic [VC_DEPTH_LOG2-1:0] rdPtr,
    output logic [CNTW-1:0]          count,
    output logic                     full,
    output logic                     empty
);
    localparam logic [CNTW-1:0]          DEPTH   = {1'b1, {VC_DEPTH_LOG2{1'b0}}};
    localparam logic [VC_DEPTH_LOG2-1:0] PTR_ONE = VC_DEPTH_LOG2'(1);

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign wrAccept = wrReq && !full;
    assign rdAccept = rdReq && !empty;

    // Pointers wrap naturally at 2^VC_DEPTH_LOG2; no explicit modulo needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrAccept) wrPtr <= wrPtr + PTR_ONE;
            if (rdAccept) rdPtr <= rdPtr + PTR_ONE;
            case ({wrAccept, rdAccept})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_packet_buffer.sv
// Multi-VC packet buffer: one shared storage array addressed {vc, pointer} with per-VC FIFO control.
// Optional VC_PACKET_BUFFER_PARITY_EN adds an even-parity bit per word and the rd_par_err output.
module vc_packet_buffer
    import noc_buf_pkg::*;
#(
    parameter int PACKET_WIDTH  = DEF_PACKET_WIDTH,
    parameter int VC_NUM        = DEF_VC_NUM,
    parameter int VC_DEPTH_LOG2 = DEF_VC_DEPTH_LOG2
) (
    input  logic               clk,
    input  logic               reset,
    vc_packet_buffer_if.slave  bus
);
    localparam int VCW   = calcVcw(VC_NUM);
    localparam int CNTW  = calcCntw(VC_DEPTH_LOG2);
    localparam int ADDRW = VCW + VC_DEPTH_LOG2;
    localparam int WORDS = 1 << ADDRW;
`ifdef VC_PACKET_BUFFER_PARITY_EN
    localparam int WORDW = PACKET_WIDTH + 1;
`else
    localparam int WORDW = PACKET_WIDTH;
`endif

    logic [WORDW-1:0]         mem [WORDS];
    logic [VC_DEPTH_LOG2-1:0] wrPtr [VC_NUM];
    logic [VC_DEPTH_LOG2-1:0] rdPtr [VC_NUM];
    logic [CNTW-1:0]          count [VC_NUM];
    logic [VC_NUM-1:0]        wrAccVec;
    logic [VC_NUM-1:0]        rdAccVec;
    logic [VC_NUM-1:0]        fullVec;
    logic [VC_NUM-1:0]        emptyVec;
    logic [VC_NUM*CNTW-1:0]   countFlat;
    logic                     wrAccept;
    logic                     rdAccept;
    logic [ADDRW-1:0]         wrAddr;
    logic [ADDRW-1:0]         rdAddr;
    logic [WORDW-1:0]         wrWord;
    logic [WORDW-1:0]         rdWord;

    for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
        vc_fifo_ctrl #(
            .VC_DEPTH_LOG2 (VC_DEPTH_LOG2)
        ) u_ctrl (
            .clk      (clk),
            .reset    (reset),
            .wrReq    (bus.wr_en && (bus.wr_vc == VCW'(i))),
            .rdReq    (bus.rd_en && (bus.rd_vc == VCW'(i))),
            .wrAccept (wrAccVec[i]),
            .rdAccept (rdAccVec[i]),
            .wrPtr    (wrPtr[i]),
            .rdPtr    (rdPtr[i]),
            .count    (count[i]),
            .full     (fullVec[i]),
            .empty    (emptyVec[i])
        );
    end

    always_comb begin
        countFlat = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            countFlat[i*CNTW +: CNTW] = count[i];
        end
    end

    assign bus.vc_full  = fullVec;
    assign bus.vc_empty = emptyVec;
    assign bus.vc_count = countFlat;

    // Only the addressed VC can accept, so the OR is exactly that VC's acceptance.
    assign wrAccept = |wrAccVec;
    assign rdAccept = |rdAccVec;
    assign wrAddr   = {bus.wr_vc, wrPtr[bus.wr_vc]};
    assign rdAddr   = {bus.rd_vc, rdPtr[bus.rd_vc]};
    assign rdWord   = mem[rdAddr];

`ifdef VC_PACKET_BUFFER_PARITY_EN
    assign wrWord = {^bus.wr_data, bus.wr_data};
`else
    assign wrWord = bus.wr_data;
`endif

    // Storage is deliberately left out of reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wrAccept) mem[wrAddr] <= wrWord;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rdAccept;
            if (rdAccept) bus.rd_data <= rdWord[PACKET_WIDTH-1:0];
        end
    end

`ifdef VC_PACKET_BUFFER_PARITY_EN
    // A clean word has even overall parity, so any odd reduction flags corruption.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.rd_par_err <= 1'b0;
        else        bus.rd_par_err <= rdAccept && (^rdWord);
    end
`endif

endmodule
